// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: one instruction in flight, req/gnt/rvalid data bus,
// byte-lane store formatting and sign/zero-extending load formatting.
module ysyx_25060170_lsu #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] exu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [2:0]  funct3_i,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] PC_i,
   input  logic [4:0]  rd_i,
   input  logic [1:0]  regS,
   input  logic        RegW,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] out_PC,
   output logic [4:0]  out_rd,
   output logic [1:0]  out_regS,
   output logic        out_RegW,
   output logic        out_err
);

   // state | meaning
   // IDLE  | waiting for an EXU result, in_ready high
   // REQ   | bus request asserted until granted
   // RSP   | waiting for rvalid, timeout counter running
   // DONE  | result presented to WBU until out_ready
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tcnt_q;
   logic [31:0]   addr_q, sd_q, pc_q, result_q;
   logic [2:0]    f3_q;
   logic          memrd_q, memwr_q, regw_q, err_q;
   logic [4:0]    rd_q;
   logic [1:0]    regs_q;

   logic        ld_ok, st_ok, misal, acc_err, is_mem;
   logic [1:0]  off;
   logic [31:0] rshift, load_fmt;

   assign is_mem = MemRd | MemWr;
   assign ld_ok  = (funct3_i == 3'b000) | (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                   (funct3_i == 3'b100) | (funct3_i == 3'b101);
   assign st_ok  = (funct3_i < 3'b011);
   assign misal  = ((funct3_i[1:0] == 2'b01) & exu_result_i[0]) |
                   ((funct3_i[1:0] == 2'b10) & (exu_result_i[1:0] != 2'b00));
   assign acc_err = (MemRd & MemWr) | (MemRd & ~ld_ok) | (MemWr & ~st_ok) | (is_mem & misal);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = (is_mem & ~acc_err) ? REQ : DONE;
         REQ:  if (mem_gnt) state_d = RSP;
         RSP:  if (mem_rvalid || tcnt_q == '0) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign off    = addr_q[1:0];
   assign rshift = mem_rdata >> {off, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  load_fmt = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_fmt = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_fmt = {24'd0, rshift[7:0]};
         3'b101:  load_fmt = {16'd0, rshift[15:0]};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tcnt_q   <= '0;
         addr_q   <= '0;
         sd_q     <= '0;
         pc_q     <= '0;
         result_q <= '0;
         f3_q     <= '0;
         memrd_q  <= 1'b0;
         memwr_q  <= 1'b0;
         regw_q   <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= '0;
         regs_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (in_valid) begin
               addr_q   <= exu_result_i;
               sd_q     <= store_data_i;
               f3_q     <= funct3_i;
               memrd_q  <= MemRd;
               memwr_q  <= MemWr;
               pc_q     <= PC_i;
               rd_q     <= rd_i;
               regs_q   <= regS;
               regw_q   <= RegW & ~acc_err & (rd_i != 5'd0);
               err_q    <= acc_err;
               result_q <= acc_err ? 32'd0 : exu_result_i;
            end
            REQ: if (mem_gnt) tcnt_q <= TW'(TIMEOUT_CYC - 1);
            RSP: begin
               if (mem_rvalid) begin
                  if (memrd_q) result_q <= load_fmt;
               end else if (tcnt_q == '0) begin
                  err_q    <= 1'b1;
                  regw_q   <= 1'b0;
                  result_q <= 32'd0;
               end else begin
                  tcnt_q <= tcnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Reset is folded in so req/valid drop in the same instant reset asserts.
   assign in_ready  = (state_q == IDLE);
   assign mem_req   = (state_q == REQ) & rst;
   assign out_valid = (state_q == DONE) & rst;
   assign mem_we    = memwr_q & (state_q == REQ);
   assign mem_addr  = {addr_q[31:2], 2'b00};

   always_comb begin
      mem_wmask = 4'b0000;
      mem_wdata = 32'd0;
      if (mem_we) begin
         case (f3_q[1:0])
            2'b00: begin
               mem_wmask = 4'b0001 << off;
               mem_wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
               mem_wmask = 4'b0011 << off;
               mem_wdata = {2{sd_q[15:0]}};
            end
            default: begin
               mem_wmask = 4'b1111;
               mem_wdata = sd_q;
            end
         endcase
      end
   end

   assign out_result = result_q;
   assign out_PC     = pc_q;
   assign out_rd     = rd_q;
   assign out_regS   = regs_q;
   assign out_RegW   = regw_q;
   assign out_err    = err_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed and randomized bench for the LSU with a byte-lane reference model.
module tb_ysyx_25060170_lsu;

   localparam int TIMEOUT_CYC = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] exu_result_i = '0, store_data_i = '0, PC_i = '0;
   logic [2:0]  funct3_i = '0;
   logic        MemRd = 1'b0, MemWr = 1'b0, RegW = 1'b0;
   logic [4:0]  rd_i = '0;
   logic [1:0]  regS = '0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result, out_PC;
   logic [4:0]  out_rd;
   logic [1:0]  out_regS;
   logic        out_RegW, out_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   ysyx_25060170_lsu #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .exu_result_i(exu_result_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
      .MemRd(MemRd), .MemWr(MemWr), .PC_i(PC_i), .rd_i(rd_i), .regS(regS), .RegW(RegW),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_PC(out_PC),
      .out_rd(out_rd), .out_regS(out_regS), .out_RegW(out_RegW), .out_err(out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit m_err(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
      if (rd && wr) return 1'b1;
      if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
      if (wr && f3 > 2) return 1'b1;
      if ((rd || wr) && (a % acc_size(f3)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_wmask(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] m = '0;
      int n = acc_size(f3);
      int o = int'(a % 4);
      for (int i = 0; i < 4; i++) if (i >= o && i < o + n) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w = '0;
      int n = acc_size(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
      longint v = 0;
      int n = acc_size(f3);
      int o = int'(a % 4);
      for (int i = 0; i < n; i++) v += longint'(rdat[8*(o+i) +: 8]) << (8*i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   // rw < 0 means the response never arrives.
   task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdat, input int gw, input int rw,
                         input int yw, input bit rgw, input logic [4:0] rdn);
      bit e, bus, to;
      logic [31:0] pc, e_res;
      logic [1:0] rs;
      int n, c0, rsp_exp, lat_exp;
      e   = m_err(rd, wr, f3, a);
      bus = (rd || wr) && !e;
      pc  = $urandom;
      rs  = 2'($urandom_range(0, 3));
      exu_result_i = a; store_data_i = sd; funct3_i = f3; MemRd = rd; MemWr = wr;
      PC_i = pc; rd_i = rdn; regS = rs; RegW = rgw; in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); @(negedge clk);
      c0 = cyc;
      in_valid = 1'b0;
      exu_result_i = $urandom; store_data_i = $urandom; PC_i = $urandom;
      funct3_i = 3'($urandom); MemRd = 1'($urandom); MemWr = 1'($urandom);
      rd_i = 5'($urandom); RegW = 1'($urandom);
      to = 1'b0; rsp_exp = 0;
      if (bus) begin
         for (int g = 0; g <= gw; g++) begin
            chk("req_hold", mem_req, 1);
            chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("req_we", mem_we, wr);
            if (wr) begin
               chk("req_wmask", mem_wmask, m_wmask(f3, a));
               chk("req_wdata", mem_wdata, m_wdata(f3, sd));
            end
            chk("in_ready_busy", in_ready, 0);
            mem_gnt = (g == gw);
            @(posedge clk); @(negedge clk);
         end
         mem_gnt = 1'b0;
         chk("req_drop", mem_req, 0);
         n = 0;
         while (!out_valid && n < 1000) begin
            mem_rvalid = (n == rw);
            mem_rdata  = (n == rw) ? rdat : $urandom;
            @(posedge clk); @(negedge clk);
            n++;
         end
         mem_rvalid = 1'b0;
         to = (rw < 0);
         rsp_exp = to ? TIMEOUT_CYC : rw + 1;
         chk("rsp_cycles", n, rsp_exp);
      end else begin
         chk("no_req", mem_req, 0);
      end
      lat_exp = bus ? 2 + gw + rsp_exp : 1;
      chk("latency", cyc - c0 + 1, lat_exp);
      e_res = (e || to) ? 32'd0 : (rd ? m_load(f3, a, rdat) : a);
      for (int k = 0; k <= yw; k++) begin
         chk("out_valid", out_valid, 1);
         chk("out_result", out_result, e_res);
         chk("out_err", out_err, e || to);
         chk("out_RegW", out_RegW, rgw && !e && !to && rdn != 0);
         chk("out_PC", out_PC, pc);
         chk("out_rd", out_rd, rdn);
         chk("out_regS", out_regS, rs);
         chk("in_ready_done", in_ready, 0);
         out_ready = (k == yw);
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
   endtask

   initial begin
      logic [31:0] ra;
      int kind;
      bit rrd, rwr;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_err", out_err, 0);
      chk("rel_out_RegW", out_RegW, 0);
      chk("rel_out_result", out_result, 0);
      chk("rel_mem_addr", mem_addr, 0);

      run_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 1, 5'd5);
      run_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 1, 5'd3);
      run_op(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 1, 5'd3);
      run_op(0, 1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 0, 0, 0, 0, 5'd0);
      run_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 0, 1, 5'd7);
      run_op(1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 3, 1, 2, 1, 5'd9);
      run_op(1, 0, 3'b001, 32'h0000_0300, 32'h0, 32'h1234_5678, 0, -1, 0, 1, 5'd4);
      run_op(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h1111_2222, 0, 0, 0, 1, 5'd0);
      run_op(1, 1, 3'b010, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0, 1, 5'd1);

      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 9);
         rrd = (kind >= 2 && kind <= 5) || kind == 9;
         rwr = (kind >= 6);
         ra = $urandom;
         run_op(rrd, rwr, 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom), 5'($urandom));
      end

      exu_result_i = 32'h40; MemRd = 1'b1; MemWr = 1'b0; funct3_i = 3'b010; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_req", mem_req, 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_idle", in_ready, 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk);
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      chk("late_rsp_valid", out_valid, 0);
      chk("late_rsp_req", mem_req, 0);
      chk("late_rsp_idle", in_ready, 1);
      run_op(0, 0, 3'b111, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, 1, 1, 5'd31);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
